// File: rtl/rom_fetch_arbiter.sv
// Shared sprite/maze ROM arbiter: round-robin with an urgent override for the
// background fetcher, and a tag pipeline that steers each returned byte home.
module rom_fetch_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic                    urgent,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    busy
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STAGES = ROM_LAT + 1;

  logic [ID_W-1:0]   ptr;
  logic              grant_any;
  logic              urgent_win;
  logic [ID_W-1:0]   winner;
  logic [STAGES-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [STAGES];

  // Scan from the highest offset down so the hit closest to ptr is kept last.
  always_comb begin
    int idx;
    idx        = 0;
    grant_any  = 1'b0;
    urgent_win = 1'b0;
    winner     = '0;
    gnt        = '0;
    if (!Reset) begin
      if (urgent && req[0]) begin
        grant_any  = 1'b1;
        urgent_win = 1'b1;
      end else begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          idx = (int'(ptr) + k) % N_REQ;
          if (req[idx]) begin
            grant_any = 1'b1;
            winner    = ID_W'(idx);
          end
        end
      end
      if (grant_any) gnt = N_REQ'(1) << winner;
    end
  end

  // Urgent grants leave the pointer alone so the rotation resumes where it was.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr      <= '0;
      rom_addr <= '0;
      tag_v    <= '0;
    end else begin
      if (grant_any && !urgent_win)
        ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      if (grant_any)
        rom_addr <= addr[int'(winner)*ADDR_W +: ADDR_W];
      tag_v <= {tag_v[STAGES-2:0], grant_any};
    end
  end

  always_ff @(posedge Clk) begin
    tag_id[0] <= winner;
    for (int k = 1; k < STAGES; k++) tag_id[k] <= tag_id[k-1];
  end

  assign rvalid = (!Reset && tag_v[STAGES-1]) ? (N_REQ'(1) << tag_id[STAGES-1]) : '0;
  assign rdata  = rom_data;
  assign busy   = !Reset && (|tag_v);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: vector table, hand sequences, a ROM_LAT=3
// instance, and a reference arbiter feeding a return scoreboard.
module tb_rom_fetch_arbiter;

  localparam int N    = 3;
  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic          Clk   = 1'b0;
  logic          Reset = 1'b1;
  logic [N-1:0]  req   = '0;
  logic [N*AW-1:0] addr = '0;
  logic          urgent = 1'b0;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata, rom_data;
  logic [AW-1:0] rom_addr;
  logic          busy;

  logic [N-1:0]  req3   = '0;
  logic [N*AW-1:0] addr3 = '0;
  logic [N-1:0]  gnt3, rvalid3;
  logic [DW-1:0] rdata3, rom_data3;
  logic [AW-1:0] rom_addr3;
  logic          busy3;

  int checks = 0;
  int errors = 0;
  int cycle_n = 0;

  always #10 Clk = ~Clk;
  always @(posedge Clk) cycle_n <= cycle_n + 1;

  rom_fetch_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .addr(addr), .urgent(urgent),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy));

  rom_fetch_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT3)) dut3 (
    .Clk(Clk), .Reset(Reset), .req(req3), .addr(addr3), .urgent(1'b0),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .rom_addr(rom_addr3),
    .rom_data(rom_data3), .busy(busy3));

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    logic [7:0] p;
    p = a[7:0] * 8'd37;
    return p ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
  endfunction

  // ROM models: data for an address appears LAT cycles after it is presented.
  logic [DW-1:0] rom_pipe  [LAT];
  logic [DW-1:0] rom_pipe3 [LAT3];
  always @(posedge Clk) begin
    rom_pipe[0] <= rom_byte(rom_addr);
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    rom_pipe3[0] <= rom_byte(rom_addr3);
    for (int k = 1; k < LAT3; k++) rom_pipe3[k] <= rom_pipe3[k-1];
  end
  assign rom_data  = rom_pipe[LAT-1];
  assign rom_data3 = rom_pipe3[LAT3-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_n);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input logic u, input int p);
    if (u && r[0]) return N'(1);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  // Scoreboard entry: {due cycle[41:10], id[9:8], data[7:0]}
  logic [41:0]   exp_q[$];
  int            m_ptr = 0;
  logic [AW-1:0] m_rom = '0;
  int            wait_cnt [N];
  int            max_wait = 0;

  always @(negedge Clk) begin
    logic [N-1:0]  eg;
    logic [41:0]   h;
    logic [AW-1:0] a;
    logic          exp_busy;
    int            w;
    if (Reset) begin
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_rvalid", 32'(rvalid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      m_ptr = 0;
      m_rom = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      eg = model_gnt(req, urgent, m_ptr);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("ptr", 32'(dut.ptr), 32'(m_ptr));
      chk("rom_addr", 32'(rom_addr), 32'(m_rom));
      exp_busy = (exp_q.size() > 0) && (int'(exp_q[0][41:10]) - LAT <= cycle_n);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cycle_n) begin
        h = exp_q.pop_front();
        chk("rvalid", 32'(rvalid), 32'(N'(1) << h[9:8]));
        chk("rdata", 32'(rdata), 32'(h[7:0]));
      end else begin
        chk("rvalid_idle", 32'(rvalid), 32'(0));
      end
      if (eg != '0) begin
        w = eg[0] ? 0 : (eg[1] ? 1 : 2);
        a = addr[w*AW +: AW];
        exp_q.push_back({32'(cycle_n + 1 + LAT), 2'(w), rom_byte(a)});
        m_rom = a;
        if (!(urgent && req[0])) m_ptr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] || gnt[i]) wait_cnt[i] = 0;
        else if (!(urgent && req[0])) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         urg;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [AW-1:0] a_a, a_b;
    // reset / round-robin from ptr=0 / urgent pulse / urgent without req0 / idle
    tbl.push_back('{1'b1, 3'b000, 1'b0, 3'b000});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b0, 3'b111, 1'b0, 3'(1 << (i % 3))});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 3'b000});
    tbl.push_back('{1'b0, 3'b110, 1'b1, 3'b010});
    tbl.push_back('{1'b0, 3'b110, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 3'b111, 1'b1, 3'b001});
    tbl.push_back('{1'b0, 3'b110, 1'b1, 3'b010});
    tbl.push_back('{1'b0, 3'b110, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 3'b110, 1'b1, 3'b010});
    tbl.push_back('{1'b0, 3'b011, 1'b0, 3'b001});
    tbl.push_back('{1'b0, 3'b101, 1'b0, 3'b100});
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 3'b000, 1'b0, 3'b000});

    repeat (3) step();
    Reset = 1'b0;
    repeat (2) step();

    // single request from requester 1
    req = 3'b010;
    addr[1*AW +: AW] = 19'h12345;
    @(negedge Clk);
    chk("single_gnt", 32'(gnt), 32'(3'b010));
    step();
    req = '0;
    @(negedge Clk);
    chk("single_rom_addr", 32'(rom_addr), 32'(19'h12345));
    chk("single_busy1", 32'(busy), 32'(1));
    step();
    @(negedge Clk);
    chk("single_rvalid", 32'(rvalid), 32'(3'b010));
    chk("single_rdata", 32'(rdata), 32'(rom_byte(19'h12345)));
    chk("single_busy2", 32'(busy), 32'(1));
    step();
    @(negedge Clk);
    chk("single_busy_end", 32'(busy), 32'(0));

    // ROM_LAT=3 instance: back-to-back grants to 2 then 0
    a_a = 19'h7_1A2B;
    a_b = 19'h0_0C3D;
    step();
    req3 = 3'b100;
    addr3[2*AW +: AW] = a_a;
    @(negedge Clk);
    chk("lat3_gnt_a", 32'(gnt3), 32'(3'b100));
    step();
    req3 = 3'b001;
    addr3[0 +: AW] = a_b;
    @(negedge Clk);
    chk("lat3_gnt_b", 32'(gnt3), 32'(3'b001));
    step();
    req3 = '0;
    @(negedge Clk);
    chk("lat3_rvalid_t2", 32'(rvalid3), 32'(0));
    step();
    @(negedge Clk);
    chk("lat3_rvalid_t3", 32'(rvalid3), 32'(0));
    step();
    @(negedge Clk);
    chk("lat3_rvalid_a", 32'(rvalid3), 32'(3'b100));
    chk("lat3_rdata_a", 32'(rdata3), 32'(rom_byte(a_a)));
    step();
    @(negedge Clk);
    chk("lat3_rvalid_b", 32'(rvalid3), 32'(3'b001));
    chk("lat3_rdata_b", 32'(rdata3), 32'(rom_byte(a_b)));
    step();
    @(negedge Clk);
    chk("lat3_busy_end", 32'(busy3), 32'(0));

    // vector table
    foreach (tbl[i]) begin
      step();
      Reset  = tbl[i].rst;
      req    = tbl[i].req;
      urgent = tbl[i].urg;
      addr   = (N*AW)'({$urandom(), $urandom()});
      @(negedge Clk);
      chk($sformatf("tbl_gnt[%0d]", i), 32'(gnt), 32'(tbl[i].exp_gnt));
    end

    // reset one cycle after a grant flushes the in-flight tag
    step();
    Reset = 1'b0; urgent = 1'b0;
    req = 3'b001;
    addr[0 +: AW] = 19'h5_5555;
    @(negedge Clk);
    chk("flush_gnt", 32'(gnt), 32'(3'b001));
    step();
    req = '0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge Clk);
    chk("flush_rvalid", 32'(rvalid), 32'(0));
    chk("flush_busy", 32'(busy), 32'(0));
    chk("flush_rom_addr", 32'(rom_addr), 32'(0));
    step();
    req = 3'b100;
    addr[2*AW +: AW] = 19'h2_468A;
    @(negedge Clk);
    chk("after_flush_gnt", 32'(gnt), 32'(3'b100));
    step();
    req = '0;
    step();
    @(negedge Clk);
    chk("after_flush_rvalid", 32'(rvalid), 32'(3'b100));
    chk("after_flush_rdata", 32'(rdata), 32'(rom_byte(19'h2_468A)));

    // random traffic, checked by the reference model
    for (int i = 0; i < 10000; i++) begin
      step();
      req    = N'($urandom_range(0, 7));
      urgent = ($urandom_range(0, 3) == 0);
      addr   = (N*AW)'({$urandom(), $urandom()});
    end
    step();
    req = '0; urgent = 1'b0;
    repeat (4) step();
    @(negedge Clk);
    chk("starvation_bound", 32'(max_wait < N), 32'(1));
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
